// File: rtl/cpu7_dbus_responder.sv
// Data-bus memory responder for the cpu7 cache pipeline: in-order request queue over a word SRAM.
// Define CPU7_DBUS_LLSC_EN to enable the ll/sc reservation; otherwise sc always succeeds.
module cpu7_dbus_responder #(
  parameter int unsigned       GRLEN     = 32,
  parameter int unsigned       MEM_AW    = 12,
  parameter logic [GRLEN-1:0]  BASE_ADDR = 32'h1c000000,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_req,
  input  logic [GRLEN-1:0] data_pc,
  input  logic             data_wr,
  input  logic [3:0]       data_wstrb,
  input  logic [GRLEN-1:0] data_addr,
  input  logic [GRLEN-1:0] data_wdata,
  input  logic             data_prefetch,
  input  logic             data_ll,
  input  logic             data_sc,
  input  logic             data_cancel,
  input  logic             data_cancel_ex2,
  input  logic             data_recv,
  output logic             data_addr_ok,
  output logic             data_data_ok_m,
  output logic [GRLEN-1:0] data_rdata_m,
  output logic             data_exception,
  output logic [5:0]       data_exccode,
  output logic [GRLEN-1:0] data_badvaddr,
  output logic             data_req_empty,
  output logic             data_scsucceed
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LatAge = AW'(LATENCY);

  typedef struct packed {
    logic             live;
    logic             wr;
    logic [3:0]       wstrb;
    logic [GRLEN-1:0] addr;
    logic [GRLEN-1:0] wdata;
    logic             pf;
    logic             ll;
    logic             sc;
    logic [AW-1:0]    age;
  } entry_t;

  entry_t            q_q [DEPTH];
  entry_t            q_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              last_vld_q, last_vld_d;
  logic [PW-1:0]     last_idx_q, last_idx_d;
  logic [GRLEN-1:0]  mem_q [2**MEM_AW];

  entry_t            head;
  logic [GRLEN-1:0]  off;
  logic [MEM_AW-1:0] widx;
  logic              oor, is_store, is_load, exc, sc_ok;
  logic              head_ready, head_kill_ex2, resp_vld, retire, push, pop, we;
  logic              unused_bits;

  assign head     = q_q[rd_ptr_q];
  assign off      = head.addr - BASE_ADDR;
  assign widx     = off[MEM_AW+1:2];
  assign oor      = (head.addr < BASE_ADDR) | (|off[GRLEN-1:MEM_AW+2]);
  assign is_store = head.wr | head.sc;
  assign is_load  = !is_store & !head.pf;
  assign exc      = !head.pf & oor;

`ifdef CPU7_DBUS_LLSC_EN
  logic              llbit_q, llbit_d;
  logic [MEM_AW-1:0] llwidx_q, llwidx_d;

  assign sc_ok = llbit_q & (widx == llwidx_q);

  always_comb begin
    llbit_d  = llbit_q;
    llwidx_d = llwidx_q;
    if (retire & !exc) begin
      if (head.ll & is_load) begin
        llbit_d  = 1'b1;
        llwidx_d = widx;
      end else if (head.sc) begin
        llbit_d = 1'b0;
      end else if (is_store & (widx == llwidx_q)) begin
        llbit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      llbit_q  <= 1'b0;
      llwidx_q <= '0;
    end else begin
      llbit_q  <= llbit_d;
      llwidx_q <= llwidx_d;
    end
  end
`else
  assign sc_ok = 1'b1;
`endif

  assign unused_bits = ^{data_pc, off[1:0], head.ll};

  // A head killed by ex2 in this very cycle must not present its response.
  assign head_kill_ex2 = data_cancel_ex2 & last_vld_q & (last_idx_q == rd_ptr_q);
  assign head_ready    = (cnt_q != '0) & head.live & (head.age == LatAge);
  assign resp_vld      = head_ready & !data_cancel & !head_kill_ex2;
  assign retire        = resp_vld & data_recv;
  assign pop           = ((cnt_q != '0) & !head.live) | retire;
  assign data_addr_ok  = (cnt_q != (PW+1)'(DEPTH)) & !data_cancel;
  assign push          = data_req & data_addr_ok;
  assign we            = retire & is_store & !exc & (!head.sc | sc_ok) & !reset;

  assign data_req_empty = (cnt_q == '0);
  assign data_data_ok_m = resp_vld;
  assign data_rdata_m   = (resp_vld & is_load & !oor) ? mem_q[widx] : '0;
  assign data_exception = resp_vld & exc;
  assign data_exccode   = data_exception ? 6'h08 : 6'h00;
  assign data_badvaddr  = data_exception ? head.addr : '0;
  assign data_scsucceed = resp_vld & head.sc & !exc & sc_ok;

  always_comb begin
    q_d        = q_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    last_vld_d = push;
    last_idx_d = wr_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_q[i].age != LatAge) q_d[i].age = q_q[i].age + 1'b1;
    end
    if (data_cancel_ex2 & last_vld_q) q_d[last_idx_q].live = 1'b0;
    if (pop) begin
      q_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d           = rd_ptr_q + 1'b1;
    end
    if (push) begin
      q_d[wr_ptr_q].live  = 1'b1;
      q_d[wr_ptr_q].wr    = data_wr;
      q_d[wr_ptr_q].wstrb = data_wstrb;
      q_d[wr_ptr_q].addr  = data_addr;
      q_d[wr_ptr_q].wdata = data_wdata;
      q_d[wr_ptr_q].pf    = data_prefetch;
      q_d[wr_ptr_q].ll    = data_ll;
      q_d[wr_ptr_q].sc    = data_sc;
      q_d[wr_ptr_q].age   = AW'(1);
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (data_cancel) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_d[i].live = 1'b0;
      cnt_d      = '0;
      rd_ptr_d   = wr_ptr_q;
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
    end else begin
      q_q        <= q_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (head.wstrb[b]) mem_q[widx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu7_dbus_responder.sv
// Bench for cpu7_dbus_responder: vector table plus hand sequences, scoreboard-checked responses.
module tb_cpu7_dbus_responder;

  localparam int LAT = 2;
`ifdef CPU7_DBUS_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif
  localparam logic [31:0] A = 32'h1c000030;

  logic        clk = 1'b0;
  logic        reset, data_req, data_wr, data_prefetch, data_ll, data_sc;
  logic        data_cancel, data_cancel_ex2, data_recv;
  logic [31:0] data_pc, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok_m, data_exception, data_req_empty, data_scsucceed;
  logic [31:0] data_rdata_m, data_badvaddr;
  logic [5:0]  data_exccode;

  cpu7_dbus_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_req        (data_req),
    .data_pc         (data_pc),
    .data_wr         (data_wr),
    .data_wstrb      (data_wstrb),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_prefetch   (data_prefetch),
    .data_ll         (data_ll),
    .data_sc         (data_sc),
    .data_cancel     (data_cancel),
    .data_cancel_ex2 (data_cancel_ex2),
    .data_recv       (data_recv),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok_m  (data_data_ok_m),
    .data_rdata_m    (data_rdata_m),
    .data_exception  (data_exception),
    .data_exccode    (data_exccode),
    .data_badvaddr   (data_badvaddr),
    .data_req_empty  (data_req_empty),
    .data_scsucceed  (data_scsucceed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pf, ll, sc;
    logic [31:0] rdata;
    logic        exc;
    logic        scs;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [5:0]  code;
    logic [31:0] badv;
    logic        scs;
    bit          chk_lat;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && data_data_ok_m && data_recv) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: got rdata=%h exc=%b, required no response",
                 data_rdata_m, data_exception);
      end else begin
        e = sb.pop_front();
        if (data_rdata_m !== e.rdata || data_exception !== e.exc || data_exccode !== e.code ||
            data_badvaddr !== e.badv || data_scsucceed !== e.scs ||
            (e.chk_lat && cyc != e.exp_cyc)) begin
          n_err++;
          $display("FAIL resp: got rdata=%h exc=%b code=%h badv=%h scs=%b cyc=%0d, required rdata=%h exc=%b code=%h badv=%h scs=%b cyc=%0d",
                   data_rdata_m, data_exception, data_exccode, data_badvaddr, data_scsucceed,
                   cyc, e.rdata, e.exc, e.code, e.badv, e.scs, e.exp_cyc);
        end
      end
    end
  end

  function automatic vec_t v(input logic wr, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] d, input logic pf, input logic ll,
                             input logic sc, input logic [31:0] rd, input logic exc,
                             input logic scs);
    vec_t r;
    r.wr = wr; r.wstrb = s; r.addr = a; r.wdata = d; r.pf = pf; r.ll = ll; r.sc = sc;
    r.rdata = rd; r.exc = exc; r.scs = scs;
    return r;
  endfunction

  function automatic vec_t ld(input logic [31:0] a, input logic [31:0] rd);
    return v(1'b0, 4'h0, a, 32'h0, 1'b0, 1'b0, 1'b0, rd, 1'b0, 1'b0);
  endfunction

  function automatic vec_t st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return v(1'b1, s, a, d, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t to_exp(input vec_t r, input bit lat, input int ec);
    exp_t x;
    x.rdata = r.rdata; x.exc = r.exc; x.code = r.exc ? 6'h08 : 6'h00;
    x.badv = r.exc ? r.addr : 32'h0; x.scs = r.scs; x.chk_lat = lat; x.exp_cyc = ec;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t r);
    data_wr = r.wr; data_wstrb = r.wstrb; data_addr = r.addr; data_wdata = r.wdata;
    data_prefetch = r.pf; data_ll = r.ll; data_sc = r.sc; data_req = 1'b1;
  endtask

  task automatic send(input vec_t r, input bit lat);
    int n;
    @(posedge clk); #1;
    drive(r);
    n = 0;
    @(negedge clk);
    while (!data_addr_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!data_addr_ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got addr_ok=0, required 1");
    end else begin
      sb.push_back(to_exp(r, lat, cyc + LAT));
    end
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back(st(32'h1c000010, 32'hdeadbeef, 4'hf));
    tbl.push_back(ld(32'h1c000010, 32'hdeadbeef));
    tbl.push_back(st(32'h1c000010, 32'h11223344, 4'b0011));
    tbl.push_back(ld(32'h1c000010, 32'hdead3344));
    tbl.push_back(ld(32'h1c000012, 32'hdead3344));
    tbl.push_back(st(32'h1c000020, 32'ha5a5a5a5, 4'hf));
    tbl.push_back(st(32'h1c000020, 32'h00000000, 4'h0));
    tbl.push_back(ld(32'h1c000020, 32'ha5a5a5a5));
    tbl.push_back(st(32'h1c000020, 32'h12345678, 4'b1100));
    tbl.push_back(ld(32'h1c000020, 32'h1234a5a5));
    tbl.push_back(v(1'b0, 4'h0, 32'h1c000010, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(st(32'h1c003ffc, 32'hcafef00d, 4'hf));
    tbl.push_back(ld(32'h1c003ffc, 32'hcafef00d));
    tbl.push_back(v(1'b0, 4'h0, 32'h1c004000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(v(1'b0, 4'h0, 32'h1bfffffc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(v(1'b1, 4'hf, 32'h1c004000, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(ld(32'h1c003ffc, 32'hcafef00d));
    tbl.push_back(st(A, 32'h1, 4'hf));
    tbl.push_back(v(1'b0, 4'h0, A, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0));
    tbl.push_back(st(A, 32'h2, 4'hf));
    tbl.push_back(v(1'b1, 4'hf, A, 32'h3, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, !LLSC));
    tbl.push_back(ld(A, LLSC ? 32'h2 : 32'h3));
    tbl.push_back(v(1'b0, 4'h0, A, 32'h0, 1'b0, 1'b1, 1'b0, LLSC ? 32'h2 : 32'h3, 1'b0, 1'b0));
    tbl.push_back(v(1'b1, 4'hf, A, 32'h4, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1));
    tbl.push_back(ld(A, 32'h4));

    reset = 1'b1; data_req = 1'b0; data_pc = 32'h1c000000; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; data_prefetch = 1'b0; data_ll = 1'b0;
    data_sc = 1'b0; data_cancel = 1'b0; data_cancel_ex2 = 1'b0; data_recv = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", {31'h0, data_req_empty}, 32'h1);
    chk("rst_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    chk("rst_data_ok", {31'h0, data_data_ok_m}, 32'h0);
    chk("rst_rdata", data_rdata_m, 32'h0);
    chk("rst_exc", {31'h0, data_exception}, 32'h0);
    chk("rst_scs", {31'h0, data_scsucceed}, 32'h0);

    foreach (tbl[i]) begin
      send(tbl[i], 1'b1);
      wait_drain();
    end

    // Backpressure: four accepted, fifth refused, head response held.
    @(posedge clk); #1 data_recv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec_t r;
      case (i)
        0: r = ld(32'h1c000010, 32'hdead3344);
        1: r = ld(32'h1c000020, 32'h1234a5a5);
        2: r = ld(32'h1c003ffc, 32'hcafef00d);
        3: r = ld(32'h1c000012, 32'hdead3344);
        default: r = ld(32'h1c000020, 32'h1234a5a5);
      endcase
      @(posedge clk); #1 drive(r);
      @(negedge clk);
      chk("bp_addr_ok", {31'h0, data_addr_ok}, (i < 4) ? 32'h1 : 32'h0);
      if (data_addr_ok) sb.push_back(to_exp(r, 1'b0, 0));
    end
    @(posedge clk); #1 data_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_ok", {31'h0, data_data_ok_m}, 32'h1);
      chk("bp_hold_rdata", data_rdata_m, 32'hdead3344);
    end
    @(posedge clk); #1 data_recv = 1'b1;
    wait_drain();

    // Cancel kills three queued stores, including a presenting head.
    @(posedge clk); #1 data_recv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive(st((i == 2) ? 32'h1c003ffc : 32'h1c000010 + 32'(i) * 16,
                                  32'hffffffff, 4'hf));
    end
    @(posedge clk); #1 data_req = 1'b0; data_cancel = 1'b1; data_recv = 1'b1;
    @(negedge clk);
    chk("cancel_data_ok", {31'h0, data_data_ok_m}, 32'h0);
    chk("cancel_addr_ok", {31'h0, data_addr_ok}, 32'h0);
    @(posedge clk); #1 data_cancel = 1'b0;
    @(negedge clk);
    chk("cancel_empty", {31'h0, data_req_empty}, 32'h1);
    repeat (4) @(posedge clk);
    send(ld(32'h1c000010, 32'hdead3344), 1'b1); wait_drain();
    send(ld(32'h1c000020, 32'h1234a5a5), 1'b1); wait_drain();
    send(ld(32'h1c003ffc, 32'hcafef00d), 1'b1); wait_drain();

    // ex2 kills the previous-cycle acceptance while the next request is pushed.
    @(posedge clk); #1 drive(ld(32'h1c000010, 32'hdead3344));
    @(posedge clk); #1 drive(ld(32'h1c000020, 32'h1234a5a5)); data_cancel_ex2 = 1'b1;
    @(negedge clk);
    if (data_addr_ok) sb.push_back(to_exp(ld(32'h1c000020, 32'h1234a5a5), 1'b0, 0));
    @(posedge clk); #1 data_req = 1'b0; data_cancel_ex2 = 1'b0;
    wait_drain();
    // ex2 with no acceptance in the previous cycle leaves a responding head alone.
    @(posedge clk); #1 drive(ld(32'h1c003ffc, 32'hcafef00d));
    @(negedge clk);
    sb.push_back(to_exp(ld(32'h1c003ffc, 32'hcafef00d), 1'b1, cyc + LAT));
    @(posedge clk); #1 data_req = 1'b0;
    @(posedge clk); #1 data_cancel_ex2 = 1'b1;
    @(posedge clk); #1 data_cancel_ex2 = 1'b0;
    wait_drain();

    // Reset mid-operation drops a pending store and the reservation.
    send(v(1'b0, 4'h0, A, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b0), 1'b1);
    wait_drain();
    @(posedge clk); #1 data_recv = 1'b0;
    @(posedge clk); #1 drive(st(32'h1c000010, 32'h0, 4'hf));
    @(posedge clk); #1 data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; data_recv = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_empty", {31'h0, data_req_empty}, 32'h1);
    send(v(1'b1, 4'hf, A, 32'h5, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, !LLSC), 1'b1); wait_drain();
    send(ld(A, LLSC ? 32'h4 : 32'h5), 1'b1); wait_drain();
    send(ld(32'h1c000010, 32'hdead3344), 1'b1); wait_drain();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
